// File: rtl/seq_data_selector.sv
// Registered channel selector: picks one of NCH input channels, manually by sel
// or by round-robin scan, and holds it in a single-entry output register.
module seq_data_selector #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_n,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [NCH-1:0]       din_valid,
  output logic [NCH-1:0]       din_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [SEL_W-1:0]     y_ch
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cand;
  logic             cand_ok;
  logic             load_ok;
  logic             grant;
  logic [WIDTH-1:0] cand_data;

  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (!mode) begin
      // sel values at or beyond NCH never match a channel, so they never qualify
      for (int unsigned k = 0; k < NCH; k++) begin
        if (sel == SEL_W'(k) && din_valid[k]) begin
          cand    = SEL_W'(k);
          cand_ok = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!cand_ok && din_valid[(32'(ptr) + i) % NCH]) begin
          cand    = SEL_W'((32'(ptr) + i) % NCH);
          cand_ok = 1'b1;
        end
      end
    end
  end

  assign load_ok = (!y_valid || y_ready) && !en_n && !rst;
  assign grant   = load_ok && cand_ok;

  always_comb begin
    din_ready = '0;
    cand_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (cand == SEL_W'(k)) begin
        din_ready[k] = grant;
        cand_data    = din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      ptr     <= '0;
    end else if (en_n) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else if (grant) begin
      y       <= cand_data;
      y_ch    <= cand;
      y_valid <= 1'b1;
      if (mode) ptr <= SEL_W'((32'(cand) + 1) % NCH);
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_data_selector.sv
// Directed self-checking bench for seq_data_selector (NCH=4 main instance,
// NCH=3 side instance for out-of-range manual select).
module tb_seq_data_selector;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_n;
  logic       mode;
  logic [1:0] sel;
  logic [7:0] din;
  logic [3:0] din_valid;
  logic [3:0] din_ready;
  logic [1:0] y;
  logic       y_valid;
  logic       y_ready;
  logic [1:0] y_ch;

  logic [2:0] din_ready3;
  logic [1:0] y3;
  logic       y_valid3;
  logic [1:0] y_ch3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_data_selector #(.WIDTH(2), .NCH(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .en_n(en_n), .mode(mode), .sel(sel),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_ch(y_ch)
  );

  seq_data_selector #(.WIDTH(2), .NCH(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .en_n(en_n), .mode(mode), .sel(sel),
    .din(din[5:0]), .din_valid(din_valid[2:0]), .din_ready(din_ready3),
    .y(y3), .y_valid(y_valid3), .y_ready(y_ready), .y_ch(y_ch3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] ey,
                           input logic [1:0] ech, input logic ev);
    check({tag, ".y"},       32'(y),       32'(ey));
    check({tag, ".y_ch"},    32'(y_ch),    32'(ech));
    check({tag, ".y_valid"}, 32'(y_valid), 32'(ev));
  endtask

  // Round-robin expectations with din=8'h39 (ch0=1, ch1=2, ch2=3, ch3=0)
  logic [1:0] rr_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] rr_y  [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [7:0] bp_din [3] = '{8'hFF, 8'hAA, 8'h55};

  initial begin
    rst = 1'b1; en_n = 1'b0; mode = 1'b0; sel = 2'd2;
    din = 8'h39; din_valid = 4'hF; y_ready = 1'b1;
    #1;
    check("rst.din_ready", 32'(din_ready), 32'h0);
    step();
    step();
    check_out("reset", 2'd0, 2'd0, 1'b0);
    check("rst.din_ready_hold", 32'(din_ready), 32'h0);

    // Manual select
    rst = 1'b0;
    #1;
    check("man.din_ready", 32'(din_ready), 32'b0100);
    check("man3.din_ready", 32'(din_ready3), 32'b100);
    step();
    check_out("man", 2'd3, 2'd2, 1'b1);
    check("man3.y", 32'(y3), 32'd3);

    sel = 2'd3;
    #1;
    check("man_sel3.din_ready", 32'(din_ready), 32'b1000);
    check("oor.din_ready", 32'(din_ready3), 32'b000);
    step();
    check_out("man_sel3", 2'd0, 2'd3, 1'b1);
    check("oor.y_valid", 32'(y_valid3), 32'd0);
    check("oor.y", 32'(y3), 32'd3);
    check("oor.y_ch", 32'(y_ch3), 32'd2);

    sel = 2'd1; din_valid = 4'b1101;
    #1;
    check("man_inval.din_ready", 32'(din_ready), 32'h0);
    step();
    check_out("man_inval", 2'd0, 2'd3, 1'b0);

    // Round-robin from reset, full throughput
    rst = 1'b1;
    step();
    rst = 1'b0; mode = 1'b1; din_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr%0d.din_ready", i), 32'(din_ready), 32'(4'b0001 << rr_ch[i]));
      step();
      check_out($sformatf("rr%0d", i), rr_y[i], rr_ch[i], 1'b1);
    end

    // Reset mid-stream with ptr=2; next grant is lowest valid channel
    rst = 1'b1;
    #1;
    check("midrst.din_ready", 32'(din_ready), 32'h0);
    step();
    check_out("midrst", 2'd0, 2'd0, 1'b0);
    rst = 1'b0; din_valid = 4'b1010;
    #1;
    check("postrst.din_ready", 32'(din_ready), 32'b0010);
    step();
    check_out("postrst", 2'd2, 2'd1, 1'b1);

    // Skip and wrap: bring ptr to 3 then only ch1 valid
    din_valid = 4'b0100;
    #1;
    check("toptr3.din_ready", 32'(din_ready), 32'b0100);
    step();
    check_out("toptr3", 2'd3, 2'd2, 1'b1);
    din_valid = 4'b0010;
    #1;
    check("wrap.din_ready", 32'(din_ready), 32'b0010);
    step();
    check_out("wrap", 2'd2, 2'd1, 1'b1);
    din_valid = 4'hF;
    #1;
    check("ptr2.din_ready", 32'(din_ready), 32'b0100);
    step();
    check_out("ptr2", 2'd3, 2'd2, 1'b1);

    // Back-pressure
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = bp_din[i];
      #1;
      check($sformatf("bp%0d.din_ready", i), 32'(din_ready), 32'h0);
      step();
      check_out($sformatf("bp%0d", i), 2'd3, 2'd2, 1'b1);
    end
    din = 8'hC6; y_ready = 1'b1;
    #1;
    check("bp_rel.din_ready", 32'(din_ready), 32'b1000);
    step();
    check_out("bp_rel", 2'd3, 2'd3, 1'b1);
    #1;
    check("ptr0.din_ready", 32'(din_ready), 32'b0001);
    step();
    check_out("ptr0", 2'd2, 2'd0, 1'b1);

    // Disable discards y and holds ptr (=1)
    en_n = 1'b1; y_ready = 1'b0;
    #1;
    check("dis.din_ready", 32'(din_ready), 32'h0);
    step();
    check_out("dis", 2'd0, 2'd0, 1'b0);
    step();
    check("dis2.din_ready", 32'(din_ready), 32'h0);
    en_n = 1'b0; y_ready = 1'b1;
    #1;
    check("resume.din_ready", 32'(din_ready), 32'b0010);
    step();
    check_out("resume", 2'd1, 2'd1, 1'b1);

    // Same-cycle mode change; manual capture leaves ptr at 2
    mode = 1'b0; sel = 2'd3;
    #1;
    check("tomanual.din_ready", 32'(din_ready), 32'b1000);
    step();
    check_out("tomanual", 2'd3, 2'd3, 1'b1);
    mode = 1'b1;
    #1;
    check("toauto.din_ready", 32'(din_ready), 32'b0100);
    step();
    check_out("toauto", 2'd0, 2'd2, 1'b1);

    // Drain with nothing valid
    din_valid = 4'h0;
    #1;
    check("drain.din_ready", 32'(din_ready), 32'h0);
    step();
    check_out("drain", 2'd0, 2'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
